// File: rtl/mer_ctrl_pkg.sv
// Shared types and constants for the MER measurement sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package mer_ctrl_pkg;

  localparam int NUM_PHASES = 4;
  localparam int PHASE_W    = $clog2(NUM_PHASES);
  localparam int ERR_W_DEF  = 56;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t PHASE_LAST = phase_t'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_MEASURE  = 3'd2,
    S_WAIT_RES = 3'd3,
    S_EVAL     = 3'd4,
    S_DONE     = 3'd5
  } sweep_state_t;

  // Symbol counter width: wide enough for both the measurement window and
  // the settle interval, so neither terminal value is ever truncated.
  function automatic int sym_cnt_width(input int log2_win, input int settle_syms);
    int settle_w;
    settle_w = (settle_syms > 1) ? $clog2(settle_syms) : 1;
    return (settle_w > log2_win) ? settle_w : log2_win;
  endfunction

endpackage

// File: rtl/sym_window_counter.sv
// Symbol-enable qualified up-counter with synchronous clear and terminal compare.
// Latency: term_hit is combinational on the enable cycle that reaches term_val.
// Backpressure: none; counting simply stalls while en is low.
module sym_window_counter #(
  parameter int W = 20
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         term_hit
);

  // Terminal is reached only on a counting enable, by exact equality.
  assign term_hit = en && (cnt == term_val);

  // Count enables; clear wins so the owner can restart at the terminal cycle.
  always_ff @(posedge sys_clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mer_phase_sweep_ctrl.sv
// Sweeps the 4 matched-filter sample phases, measures error energy per phase, holds the best.
// Latency: full sweep = 4*(SETTLE_SYMS+2^LOG2_WIN) symbols + 4*(RES_LAT+1)+1 sys_clk cycles.
// Backpressure: none; sym_clk_en gaps only stall symbol counting, start is ignored while busy.
module mer_phase_sweep_ctrl
  import mer_ctrl_pkg::*;
#(
  parameter int LOG2_WIN    = 20,
  parameter int SETTLE_SYMS = 64,
  parameter int RES_LAT     = 2,
  parameter int ERR_W       = ERR_W_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             start,
  input  logic             cont_mode,
  input  logic [ERR_W-1:0] err_sq_in,
  output logic [1:0]       phase_sel,
  output logic             clr_acc,
  output logic             busy,
  output logic             meas_valid,
  output logic [ERR_W-1:0] meas_err,
  output logic             done,
  output logic [1:0]       best_phase,
  output logic [ERR_W-1:0] best_err
);

  localparam int CNT_W  = sym_cnt_width(LOG2_WIN, SETTLE_SYMS);
  // RES_LAT is assumed to be at least 1.
  localparam int WAIT_W = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_SYMS - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'((1 << LOG2_WIN) - 1);
  localparam logic [WAIT_W-1:0] RES_LAST    = WAIT_W'(RES_LAT - 1);

  sweep_state_t      state_q;
  sweep_state_t      state_d;
  phase_t            phase_q;
  logic [WAIT_W-1:0] wait_cnt_q;

  logic              counting;
  logic              cnt_en;
  logic              cnt_clr;
  logic [CNT_W-1:0]  term_val;
  logic [CNT_W-1:0]  sym_cnt;
  logic              term_hit;

  // The symbol counter only runs in SETTLE/MEASURE and is held at zero
  // elsewhere, so each interval always starts from a clean count.
  assign counting = (state_q == S_SETTLE) || (state_q == S_MEASURE);
  assign cnt_en   = counting && sym_clk_en;
  assign cnt_clr  = !counting || term_hit;
  assign term_val = (state_q == S_SETTLE) ? SETTLE_LAST : WIN_LAST;

  sym_window_counter #(
    .W (CNT_W)
  ) u_sym_cnt (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .term_val (term_val),
    .cnt      (sym_cnt),
    .term_hit (term_hit)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; clr_acc fires only on the two window-boundary transitions.
  always_comb begin
    state_d = state_q;
    clr_acc = 1'b0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (term_hit) begin
          clr_acc = 1'b1;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (term_hit) begin
          clr_acc = 1'b1;
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (wait_cnt_q == RES_LAST) state_d = S_EVAL;
      end
      S_EVAL: begin
        state_d = (phase_q == PHASE_LAST) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = cont_mode ? S_SETTLE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Accumulator result latency: count sys_clk cycles spent in WAIT_RES.
  always_ff @(posedge sys_clk) begin
    if (reset || (state_q != S_WAIT_RES)) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  // Phase under test and the tap select driven into the symbol MUX.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      phase_q   <= '0;
      phase_sel <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            phase_q   <= '0;
            phase_sel <= '0;
          end
        end
        S_EVAL: begin
          if (phase_q != PHASE_LAST) begin
            phase_q   <= phase_q + phase_t'(1);
            phase_sel <= phase_q + phase_t'(1);
          end
        end
        S_DONE: begin
          // A continuous restart goes straight back to phase 0; otherwise
          // park the tap on the winner.
          phase_q   <= '0;
          phase_sel <= cont_mode ? 2'd0 : best_phase;
        end
        default: begin
        end
      endcase
    end
  end

  // Per-phase result capture and running minimum; phase 0 always seeds the
  // minimum so the previous sweep's winner is held until then.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      meas_valid <= 1'b0;
      meas_err   <= '0;
      best_phase <= '0;
      best_err   <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (state_q == S_EVAL) begin
        meas_valid <= 1'b1;
        meas_err   <= err_sq_in;
        if ((phase_q == '0) || (err_sq_in < best_err)) begin
          best_err   <= err_sq_in;
          best_phase <= phase_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mer_phase_sweep_ctrl.sv
// Self-checking bench for mer_phase_sweep_ctrl with a behavioural sweep model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mer_phase_sweep_ctrl;

  localparam int LOG2_WIN    = 4;
  localparam int SETTLE_SYMS = 8;
  localparam int RES_LAT     = 2;
  localparam int ERR_W       = 56;
  localparam int WIN         = 1 << LOG2_WIN;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             sym_clk_en;
  logic             start;
  logic             cont_mode;
  logic [ERR_W-1:0] err_sq_in;
  logic [1:0]       phase_sel;
  logic             clr_acc;
  logic             busy;
  logic             meas_valid;
  logic [ERR_W-1:0] meas_err;
  logic             done;
  logic [1:0]       best_phase;
  logic [ERR_W-1:0] best_err;

  mer_phase_sweep_ctrl #(
    .LOG2_WIN    (LOG2_WIN),
    .SETTLE_SYMS (SETTLE_SYMS),
    .RES_LAT     (RES_LAT),
    .ERR_W       (ERR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sym_clk_en (sym_clk_en),
    .start      (start),
    .cont_mode  (cont_mode),
    .err_sq_in  (err_sq_in),
    .phase_sel  (phase_sel),
    .clr_acc    (clr_acc),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_err   (meas_err),
    .done       (done),
    .best_phase (best_phase),
    .best_err   (best_err)
  );

  always #5 sys_clk = ~sys_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // stimulus requests, applied just after the next rising edge
  logic req_reset = 1'b1;
  logic req_start = 1'b0;
  logic req_cont  = 1'b0;
  bit   sym_on    = 1'b1;
  int   sym_off   = 0;
  int   cyc       = 0;

  // accumulator model: per-phase results, garbage until RES_LAT after a window edge
  logic [ERR_W-1:0] tbl [4];
  int since_clr = 100;

  // sweep observation
  int               sym_since  = 0;
  int               clr_idx    = 0;
  int               sweep_clrs = 0;
  int               done_cnt   = 0;
  logic [ERR_W-1:0] meas_q [$];
  logic [1:0]       done_bp;
  logic [ERR_W-1:0] done_be;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Winner per the selection rule: strictly smaller wins, ties keep the lower phase.
  task automatic model_best(output logic [1:0] bp, output logic [ERR_W-1:0] be);
    bp = 2'd0;
    be = tbl[0];
    for (int i = 1; i < 4; i++) begin
      if (tbl[i] < be) begin
        be = tbl[i];
        bp = 2'(i);
      end
    end
  endtask

  task automatic monitor();
    if (sym_clk_en && !done) sym_since++;
    if (clr_acc) begin
      check_val("clr_on_sym", 64'(sym_clk_en), 64'd1);
      check_val("clr_phase_sel", 64'(phase_sel), 64'(clr_idx / 2));
      check_val("clr_spacing", 64'(sym_since), 64'((clr_idx % 2 == 0) ? SETTLE_SYMS : WIN));
      clr_idx++;
      sym_since = 0;
      since_clr = 0;
    end
    if (meas_valid) meas_q.push_back(meas_err);
    if (done) begin
      done_cnt++;
      done_bp    = best_phase;
      done_be    = best_err;
      sweep_clrs = clr_idx;
      clr_idx    = 0;
      sym_since  = 0;
    end
    if (start && !busy) begin
      clr_idx   = 0;
      sym_since = 0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    reset      = req_reset;
    start      = req_start;
    cont_mode  = req_cont;
    sym_clk_en = sym_on && ((cyc % 4) == sym_off);
    if (since_clr < 1000) since_clr++;
    if (since_clr >= RES_LAT) err_sq_in = tbl[phase_sel];
    else                      err_sq_in = ERR_W'($urandom_range(0, 2000));
    @(negedge sys_clk);
    if (!reset) monitor();
  endtask

  task automatic start_sweep();
    meas_q.delete();
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    if (done_cnt == d0) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_clr(input int n, input int budget);
    for (int i = 0; i < budget && clr_idx < n; i++) tick();
    if (clr_idx < n) check_val("clr_timeout", 64'(clr_idx), 64'(n));
  endtask

  task automatic check_sweep(input string tag);
    logic [1:0]       bp;
    logic [ERR_W-1:0] be;
    model_best(bp, be);
    check_val({tag, "_nmeas"}, 64'(meas_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < meas_q.size()) check_val({tag, "_meas_err"}, 64'(meas_q[i]), 64'(tbl[i]));
    end
    check_val({tag, "_nclr"}, 64'(sweep_clrs), 64'd8);
    check_val({tag, "_best_phase"}, 64'(done_bp), 64'(bp));
    check_val({tag, "_best_err"}, 64'(done_be), 64'(be));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_phase_sel"}, 64'(phase_sel), 64'd0);
    check_val({tag, "_clr_acc"}, 64'(clr_acc), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_meas_valid"}, 64'(meas_valid), 64'd0);
    check_val({tag, "_meas_err"}, 64'(meas_err), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_best_phase"}, 64'(best_phase), 64'd0);
    check_val({tag, "_best_err"}, 64'(best_err), 64'd0);
  endtask

  task automatic rand_tbl();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) tbl[i] = ERR_W'({$urandom(), $urandom()});
      else                          tbl[i] = ERR_W'($urandom_range(0, 999));
    end
    if ($urandom_range(0, 1) == 1) tbl[$urandom_range(1, 3)] = tbl[$urandom_range(0, 3)];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]       prev_bp;
    logic [ERR_W-1:0] prev_be;
    int               d0;
    int               c0;

    reset      = 1'b1;
    start      = 1'b0;
    cont_mode  = 1'b0;
    sym_clk_en = 1'b0;
    err_sq_in  = '0;
    tbl        = '{56'd0, 56'd0, 56'd0, 56'd0};

    // reset state
    for (int i = 0; i < 3; i++) tick();
    req_reset = 1'b0;
    tick();
    check_zero("rst");

    // basic sweep
    sym_off = $urandom_range(0, 3);
    tbl = '{56'd40, 56'd25, 56'd30, 56'd50};
    start_sweep();
    wait_done(2000);
    check_sweep("basic");
    tick();
    check_val("basic_idle_busy", 64'(busy), 64'd0);
    check_val("basic_idle_phase_sel", 64'(phase_sel), 64'd1);

    // ties keep the lower phase
    tbl = '{56'd30, 56'd30, 56'd20, 56'd20};
    start_sweep();
    wait_done(2000);
    check_sweep("tie");
    tick();
    check_val("tie_idle_phase_sel", 64'(phase_sel), 64'd2);

    // randomized sweeps
    for (int n = 0; n < 4; n++) begin
      sym_off = $urandom_range(0, 3);
      rand_tbl();
      start_sweep();
      wait_done(2000);
      check_sweep("rnd");
      tick();
      check_val("rnd_idle_phase_sel", 64'(phase_sel), 64'(done_bp));
    end

    // symbol gap in the middle of a measurement window
    rand_tbl();
    start_sweep();
    wait_clr(3, 2000);
    for (int i = 0; i < 5; i++) tick();
    sym_on = 1'b0;
    c0 = clr_idx;
    for (int i = 0; i < 100; i++) tick();
    check_val("gap_no_clr", 64'(clr_idx), 64'(c0));
    sym_on = 1'b1;
    wait_done(2000);
    check_sweep("gap");

    // reset while measuring phase 2
    rand_tbl();
    start_sweep();
    wait_clr(5, 2000);
    for (int i = 0; i < 6; i++) tick();
    check_val("pre_rst_phase_sel", 64'(phase_sel), 64'd2);
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    tick();
    check_zero("mid_rst");
    clr_idx   = 0;
    sym_since = 0;
    rand_tbl();
    start_sweep();
    wait_done(2000);
    check_sweep("post_rst");

    // start held high for the whole sweep
    rand_tbl();
    meas_q.delete();
    d0 = done_cnt;
    req_start = 1'b1;
    wait_done(2000);
    req_start = 1'b0;
    check_sweep("held");
    for (int i = 0; i < 40; i++) tick();
    check_val("held_one_done", 64'(done_cnt), 64'(d0 + 1));
    check_val("held_busy", 64'(busy), 64'd0);
    check_val("held_no_clr", 64'(clr_idx), 64'd0);

    // continuous mode: back-to-back sweeps, winner held until new phase 0 result
    req_cont = 1'b1;
    rand_tbl();
    start_sweep();
    wait_done(2000);
    check_sweep("cont1");
    prev_bp = done_bp;
    prev_be = done_be;
    meas_q.delete();
    rand_tbl();
    tick();
    check_val("cont_restart_busy", 64'(busy), 64'd1);
    check_val("cont_restart_phase_sel", 64'(phase_sel), 64'd0);
    wait_clr(1, 2000);
    check_val("cont_hold_best_phase", 64'(best_phase), 64'(prev_bp));
    check_val("cont_hold_best_err", 64'(best_err), 64'(prev_be));
    req_cont = 1'b0;
    wait_done(2000);
    check_sweep("cont2");
    tick();
    check_val("cont_stop_busy", 64'(busy), 64'd0);

    // reset and start together
    req_reset = 1'b1;
    req_start = 1'b1;
    tick();
    req_reset = 1'b0;
    req_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_start_busy", 64'(busy), 64'd0);
    end
    check_val("rst_start_best_err", 64'(best_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
